// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constant multipliers, state/column types, FSM states.
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1b;

   // state[3-r][3-c] is byte(r,c), so state[3][3] lands on bits [127:120]
   typedef logic [3:0][3:0][7:0] state_t;
   typedef logic [3:0][7:0]      col_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COL  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // Inverse coefficients are sums of the x2/x4/x8 chain
   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mulb(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_muld(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mule(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational MixColumns for one 32-bit column; inv selects the inverse matrix.
module mix_column_word
   import aes_pkg::*;
(
   input  col_t col,
   input  logic inv,
   output col_t mixed
);

   logic [7:0] s0, s1, s2, s3;

   always_comb begin
      s0 = col[3];
      s1 = col[2];
      s2 = col[1];
      s3 = col[0];
      mixed = '0;
      if (inv) begin
         mixed[3] = gf_mule(s0) ^ gf_mulb(s1) ^ gf_muld(s2) ^ gf_mul9(s3);
         mixed[2] = gf_mul9(s0) ^ gf_mule(s1) ^ gf_mulb(s2) ^ gf_muld(s3);
         mixed[1] = gf_muld(s0) ^ gf_mul9(s1) ^ gf_mule(s2) ^ gf_mulb(s3);
         mixed[0] = gf_mulb(s0) ^ gf_muld(s1) ^ gf_mul9(s2) ^ gf_mule(s3);
      end else begin
         mixed[3] = gf_mul2(s0) ^ gf_mul3(s1) ^ s2 ^ s3;
         mixed[2] = s0 ^ gf_mul2(s1) ^ gf_mul3(s2) ^ s3;
         mixed[1] = s0 ^ s1 ^ gf_mul2(s2) ^ gf_mul3(s3);
         mixed[0] = gf_mul3(s0) ^ s1 ^ s2 ^ gf_mul2(s3);
      end
   end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns stage, one column per clock through a shared column multiplier.
// Define MXC_INV_EN to add the Dec_MXC port and inverse MixColumns support.
module mix_columns
   import aes_pkg::*;
(
   input  logic         Clk,
   input  logic         Rst,
   input  logic         En_MXC,
   input  logic [127:0] In_MXC,
`ifdef MXC_INV_EN
   input  logic         Dec_MXC,
`endif
   output logic         Ry_MXC,
   output logic         Busy_MXC,
   output logic [127:0] Out_MXC
);

   fsm_t       fsm;
   state_t     work;
   state_t     work_next;
   logic [1:0] cnt;
   logic [1:0] cidx;
   logic       inv;
   logic       dec_sel;
   col_t       col_in;
   col_t       col_out;

`ifdef MXC_INV_EN
   assign dec_sel = Dec_MXC;
`else
   assign dec_sel = 1'b0;
`endif

   // Column c sits at the reversed packed index 3-c
   assign cidx = ~cnt;

   always_comb begin
      col_in = {work[3][cidx], work[2][cidx], work[1][cidx], work[0][cidx]};
      work_next = work;
      work_next[3][cidx] = col_out[3];
      work_next[2][cidx] = col_out[2];
      work_next[1][cidx] = col_out[1];
      work_next[0][cidx] = col_out[0];
   end

   mix_column_word u_word (
      .col   (col_in),
      .inv   (inv),
      .mixed (col_out)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         fsm      <= IDLE;
         cnt      <= 2'd0;
         inv      <= 1'b0;
         work     <= '0;
         Ry_MXC   <= 1'b0;
         Busy_MXC <= 1'b0;
         Out_MXC  <= '0;
      end else begin
         Ry_MXC <= 1'b0;
         case (fsm)
            IDLE: begin
               if (En_MXC) begin
                  work     <= In_MXC;
                  cnt      <= 2'd0;
                  inv      <= dec_sel;
                  Busy_MXC <= 1'b1;
                  fsm      <= COL;
               end
            end
            COL: begin
               work <= work_next;
               cnt  <= cnt + 2'd1;
               if (cnt == 2'd3)
                  fsm <= DONE;
            end
            DONE: begin
               Out_MXC  <= work;
               Ry_MXC   <= 1'b1;
               Busy_MXC <= 1'b0;
               fsm      <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: vector table, scoreboard, En-hold and reset-abort sequences.
module tb_mix_columns;

   logic         Clk = 1'b0;
   logic         Rst;
   logic         En_MXC;
   logic [127:0] In_MXC;
`ifdef MXC_INV_EN
   logic         Dec_MXC;
`endif
   logic         Ry_MXC;
   logic         Busy_MXC;
   logic [127:0] Out_MXC;

   mix_columns dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .En_MXC   (En_MXC),
      .In_MXC   (In_MXC),
`ifdef MXC_INV_EN
      .Dec_MXC  (Dec_MXC),
`endif
      .Ry_MXC   (Ry_MXC),
      .Busy_MXC (Busy_MXC),
      .Out_MXC  (Out_MXC)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rycnt = 0;
   int ry_cyc_last = 0;
   int ry_cyc_prev = 0;
   logic [127:0] sb[$];
   logic [127:0] last_out;

   localparam logic [127:0] FIPS_IN  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
   localparam logic [127:0] FIPS_OUT = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Bit-serial GF(2^8) multiply, independent of the xtime-chain formulation
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      logic       hi;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         hi = x[7];
         x = {x[6:0], 1'b0};
         if (hi) x = x ^ 8'h1b;
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   function automatic logic [127:0] mc_ref(input logic [127:0] s, input bit inv);
      logic [7:0]   co[4];
      logic [7:0]   acc;
      logic [127:0] r;
      if (inv) begin
         co[0] = 8'h0e; co[1] = 8'h0b; co[2] = 8'h0d; co[3] = 8'h09;
      end else begin
         co[0] = 8'h02; co[1] = 8'h03; co[2] = 8'h01; co[3] = 8'h01;
      end
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gmul(co[(k - row + 4) % 4], s[127 - 32*k - 8*c -: 8]);
            r[127 - 32*row - 8*c -: 8] = acc;
         end
      end
      return r;
   endfunction

   always @(posedge Clk) cyc <= cyc + 1;

   // Scoreboard: every Ry pulse must match the oldest expected result
   always @(negedge Clk) begin
      if (Rst && Ry_MXC) begin
         rycnt = rycnt + 1;
         ry_cyc_prev = ry_cyc_last;
         ry_cyc_last = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_ry", 128'(rycnt), 128'(0));
         end else begin
            chk("sb_data", Out_MXC, sb.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_block(input logic [127:0] din, input logic [127:0] exp, input bit dec);
      int  n;
      bit  got;
      sb.push_back(exp);
      En_MXC = 1'b1;
      In_MXC = din;
`ifdef MXC_INV_EN
      Dec_MXC = dec;
`endif
      tick();
      En_MXC = 1'b0;
      In_MXC = {$urandom, $urandom, $urandom, $urandom};
`ifdef MXC_INV_EN
      Dec_MXC = ~dec;
`endif
      n = 0;
      got = 0;
      while (n < 10 && !got) begin
         tick();
         n++;
         if (n == 2) begin
            chk("out_hold", Out_MXC, last_out);
            chk("busy_mid", 128'(Busy_MXC), 128'(1));
         end
         if (Ry_MXC) got = 1;
      end
      chk("latency", 128'(n), 128'(5));
      chk("busy_at_ry", 128'(Busy_MXC), 128'(0));
      tick();
      chk("ry_one_cycle", 128'(Ry_MXC), 128'(0));
      last_out = exp;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int left;
      int base;
      logic [127:0] last_exp;

      vecs[0] = '{FIPS_IN, FIPS_OUT};
      vecs[1] = '{{4{32'h01010101}}, {4{32'h01010101}}};
      vecs[2] = '{{16{8'hff}}, {16{8'hff}}};
      vecs[3] = '{128'h0, 128'h0};
      vecs[4] = '{128'hd42dc601_d426c601_d431c601_d54cc601,
                  128'hd54dc601_d57ec601_d7bdc601_d6f8c601};

      Rst = 1'b0;
      En_MXC = 1'b0;
      In_MXC = '0;
`ifdef MXC_INV_EN
      Dec_MXC = 1'b0;
`endif
      last_out = '0;
      repeat (3) tick();
      chk("rst_ry", 128'(Ry_MXC), 128'(0));
      chk("rst_busy", 128'(Busy_MXC), 128'(0));
      chk("rst_out", Out_MXC, 128'h0);
      #2 Rst = 1'b1;

      for (int i = 0; i < 5; i++)
         send_block(vecs[i].din, vecs[i].exp, 1'b0);

      send_block(FIPS_OUT, mc_ref(FIPS_OUT, 1'b0), 1'b0);

`ifdef MXC_INV_EN
      send_block(FIPS_OUT, FIPS_IN, 1'b1);
      send_block(FIPS_IN, FIPS_OUT, 1'b0);
`endif

      // En held high for 12 edges: only captures from IDLE count
      base = rycnt;
      left = 0;
      last_exp = last_out;
      for (int i = 0; i < 12; i++) begin
         In_MXC = {$urandom, $urandom, $urandom, $urandom};
         En_MXC = 1'b1;
`ifdef MXC_INV_EN
         Dec_MXC = 1'b0;
`endif
         if (left > 0) begin
            left--;
         end else begin
            last_exp = mc_ref(In_MXC, 1'b0);
            sb.push_back(last_exp);
            left = 5;
         end
         tick();
      end
      En_MXC = 1'b0;
      repeat (8) tick();
      chk("hold_ry_count", 128'(rycnt - base), 128'(2));
      chk("hold_ry_spacing", 128'(ry_cyc_last - ry_cyc_prev), 128'(6));
      chk("hold_sb_empty", 128'(sb.size()), 128'(0));
      last_out = last_exp;

      // Asynchronous reset mid-block while cnt=2
      En_MXC = 1'b1;
      In_MXC = FIPS_IN;
      tick();
      En_MXC = 1'b0;
      tick();
      tick();
      #3 Rst = 1'b0;
      #1;
      chk("abort_out", Out_MXC, 128'h0);
      chk("abort_ry", 128'(Ry_MXC), 128'(0));
      chk("abort_busy", 128'(Busy_MXC), 128'(0));
      @(posedge Clk);
      #2 Rst = 1'b1;
      base = rycnt;
      repeat (8) tick();
      chk("abort_no_ry", 128'(rycnt), 128'(base));
      last_out = '0;
      send_block(FIPS_IN, FIPS_OUT, 1'b0);

      chk("final_sb_empty", 128'(sb.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
